// File: rtl/axi_sram_slave_if.sv
// axi_sram_slave_if: AXI3 slave that maps 32-bit INCR bursts onto a single-port
// synchronous SRAM with 16-bit words. Each AXI beat becomes two SRAM accesses,
// low half first, and only one transaction is in flight at a time.
// Optional build macro: AXI_SRAM_WR_PROTECT_EN -- writes are accepted with the
// normal handshakes but never reach the SRAM, and every write answers SLVERR.
//
// Handshake rule on every AXI channel: a transfer happens on the rising ACLK
// edge where VALID and READY are both high; READY is only raised in the state
// that owns the channel, and a raised VALID holds its payload until accepted.
module axi_sram_slave_if #(
  parameter int MEM_ADDRW = 22,
  parameter int MEM_DW    = 16,
  parameter int A         = 32,
  parameter int I         = 4,
  parameter int L         = 8,
  parameter int D         = 32,
  parameter int M         = 4
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,   // active-high despite the name
  input  logic [I-1:0]         AWID,
  input  logic [A-1:0]         AWADDR,
  input  logic [L-1:0]         AWLEN,
  input  logic [2:0]           AWSIZE,
  input  logic [1:0]           AWBURST,
  input  logic [1:0]           AWLOCK,
  input  logic [3:0]           AWCACHE,
  input  logic [2:0]           AWPROT,
  input  logic                 AWVALID,
  output logic                 AWREADY,
  input  logic [I-1:0]         WID,
  input  logic [D-1:0]         WDATA,
  input  logic [M-1:0]         WSTRB,
  input  logic                 WLAST,
  input  logic                 WVALID,
  output logic                 WREADY,
  output logic [I-1:0]         BID,
  output logic [1:0]           BRESP,
  output logic                 BVALID,
  input  logic                 BREADY,
  input  logic [I-1:0]         ARID,
  input  logic [A-1:0]         ARADDR,
  input  logic [L-1:0]         ARLEN,
  input  logic [2:0]           ARSIZE,
  input  logic [1:0]           ARBURST,
  input  logic [1:0]           ARLOCK,
  input  logic [3:0]           ARCACHE,
  input  logic [2:0]           ARPROT,
  input  logic                 ARVALID,
  output logic                 ARREADY,
  output logic [I-1:0]         RID,
  output logic [D-1:0]         RDATA,
  output logic [1:0]           RRESP,
  output logic                 RLAST,
  output logic                 RVALID,
  input  logic                 RREADY,
  output logic [MEM_ADDRW-1:0] mem_addr,
  output logic                 mem_we,
  output logic [MEM_DW-1:0]    mem_di,
  input  logic [MEM_DW-1:0]    mem_do,
  output logic [3:0]           dbg_state_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_LO, S_RD_HI, S_RD_CAP, S_RD_OUT,
    S_WR_WAIT, S_WR_LO, S_WR_HI, S_WR_RESP
  } state_t;

  localparam logic [L-1:0]         BEAT_ONE  = 1;
  localparam logic [MEM_ADDRW-1:0] ADDR_ONE  = 1;
  localparam logic [MEM_ADDRW-1:0] ADDR_STEP = 2;

  state_t                 state_q, state_d;
  logic [I-1:0]           id_q, id_d;
  logic [MEM_ADDRW-1:0]   addr_q, addr_d;
  logic [L-1:0]           len_q, len_d;
  logic [L-1:0]           beat_q, beat_d;
  logic [D-1:0]           rdata_q, rdata_d;
  logic [D-1:0]           wdata_q, wdata_d;
  logic [M-1:0]           wstrb_q, wstrb_d;
  logic                   err_q, err_d;
  logic                   last_beat;

  // Size/burst/lock/cache/prot and WID carry nothing this bridge uses.
  logic unused_inputs;
  assign unused_inputs = ^{AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT,
                           ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, WID,
                           AWADDR[A-1:MEM_ADDRW+1], AWADDR[0],
                           ARADDR[A-1:MEM_ADDRW+1], ARADDR[0]};

  assign last_beat   = (beat_q == len_q);
  assign RID         = id_q;
  assign BID         = id_q;
  assign RDATA       = rdata_q;
  assign RRESP       = 2'b00;
  assign dbg_state_o = state_q;

  // FSM state register
  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Burst context and data registers
  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) begin
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      err_q   <= 1'b0;
    end else begin
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      err_q   <= err_d;
    end
  end

  // Next-state, next-register values and all handshake/SRAM outputs
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    addr_d   = addr_q;
    len_d    = len_q;
    beat_d   = beat_q;
    rdata_d  = rdata_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    err_d    = err_q;
    AWREADY  = 1'b0;
    ARREADY  = 1'b0;
    WREADY   = 1'b0;
    BVALID   = 1'b0;
    BRESP    = 2'b00;
    RVALID   = 1'b0;
    RLAST    = 1'b0;
    mem_addr = '0;
    mem_we   = 1'b0;
    mem_di   = '0;
    case (state_q)
      S_IDLE: begin
        // Writes win a simultaneous request.
        AWREADY = AWVALID;
        ARREADY = ARVALID & ~AWVALID;
        if (AWVALID) begin
          id_d    = AWID;
          addr_d  = AWADDR[MEM_ADDRW:1];
          len_d   = AWLEN;
          beat_d  = '0;
          err_d   = 1'b0;
          state_d = S_WR_WAIT;
        end else if (ARVALID) begin
          id_d    = ARID;
          addr_d  = ARADDR[MEM_ADDRW:1];
          len_d   = ARLEN;
          beat_d  = '0;
          state_d = S_RD_LO;
        end
      end
      S_RD_LO: begin
        mem_addr = addr_q;
        state_d  = S_RD_HI;
      end
      S_RD_HI: begin
        // mem_do now holds the low half addressed in the previous cycle.
        mem_addr          = addr_q + ADDR_ONE;
        rdata_d[15:0]     = mem_do;
        state_d           = S_RD_CAP;
      end
      S_RD_CAP: begin
        rdata_d[31:16] = mem_do;
        state_d        = S_RD_OUT;
      end
      S_RD_OUT: begin
        RVALID = 1'b1;
        RLAST  = last_beat;
        if (RREADY) begin
          if (last_beat) begin
            state_d = S_IDLE;
          end else begin
            beat_d  = beat_q + BEAT_ONE;
            addr_d  = addr_q + ADDR_STEP;
            state_d = S_RD_LO;
          end
        end
      end
      S_WR_WAIT: begin
        WREADY = 1'b1;
        if (WVALID) begin
          wdata_d = WDATA;
          wstrb_d = WSTRB;
          // A WLAST that disagrees with AWLEN poisons the whole burst.
          if (WLAST != last_beat) err_d = 1'b1;
          state_d = S_WR_LO;
        end
      end
      S_WR_LO: begin
        mem_addr = addr_q;
        mem_di   = wdata_q[15:0];
`ifdef AXI_SRAM_WR_PROTECT_EN
        mem_we   = 1'b0;
`else
        mem_we   = |wstrb_q[1:0];
`endif
        state_d  = S_WR_HI;
      end
      S_WR_HI: begin
        mem_addr = addr_q + ADDR_ONE;
        mem_di   = wdata_q[31:16];
`ifdef AXI_SRAM_WR_PROTECT_EN
        mem_we   = 1'b0;
`else
        mem_we   = |wstrb_q[3:2];
`endif
        if (last_beat) begin
          state_d = S_WR_RESP;
        end else begin
          beat_d  = beat_q + BEAT_ONE;
          addr_d  = addr_q + ADDR_STEP;
          state_d = S_WR_WAIT;
        end
      end
      S_WR_RESP: begin
        BVALID = 1'b1;
`ifdef AXI_SRAM_WR_PROTECT_EN
        BRESP  = 2'b10;
`else
        BRESP  = err_q ? 2'b10 : 2'b00;
`endif
        if (BREADY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_sram_slave_if.sv
// Directed bench for axi_sram_slave_if with a registered 16-bit SRAM model.
module tb_axi_sram_slave_if;

`ifdef AXI_SRAM_WR_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic ACLK = 1'b0;
  logic ARESETn = 1'b1;
  always #5 ACLK = ~ACLK;

  logic [3:0]  AWID = '0, ARID = '0, WID = '0;
  logic [31:0] AWADDR = '0, ARADDR = '0, WDATA = '0;
  logic [7:0]  AWLEN = '0, ARLEN = '0;
  logic [3:0]  WSTRB = '0;
  logic        AWVALID = 1'b0, ARVALID = 1'b0, WVALID = 1'b0, WLAST = 1'b0;
  logic        BREADY = 1'b0, RREADY = 1'b0;
  logic        AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST;
  logic [3:0]  BID, RID, dbg_state;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] RDATA;
  logic [21:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_di, mem_do;

  axi_sram_slave_if dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(3'd2), .AWBURST(2'd1),
    .AWLOCK(2'd0), .AWCACHE(4'd0), .AWPROT(3'd0), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(3'd2), .ARBURST(2'd1),
    .ARLOCK(2'd0), .ARCACHE(4'd0), .ARPROT(3'd0), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_di(mem_di), .mem_do(mem_do),
    .dbg_state_o(dbg_state)
  );

  // ---------------- SRAM model with backdoor preload port ----------------
  logic [15:0] mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;
  always @(posedge ACLK) begin
    if (pl_en)       mem[pl_addr] <= pl_data;
    else if (mem_we) mem[mem_addr[9:0]] <= mem_di;
    mem_do <= mem[mem_addr[9:0]];
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks (drive/sample #1 after posedge) ----------------
  task automatic preload(input logic [9:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge ACLK); #1;
    pl_en = 1'b0;
  endtask

  task automatic ar_hs(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len);
    int k = 0;
    ARID = id; ARADDR = a; ARLEN = len; ARVALID = 1'b1;
    #1;
    while (!ARREADY && k < 50) begin @(posedge ACLK); #1; k++; end
    check_eq("arready", {31'd0, ARREADY}, 32'd1);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
  endtask

  task automatic aw_hs(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len);
    int k = 0;
    AWID = id; AWADDR = a; AWLEN = len; AWVALID = 1'b1;
    #1;
    while (!AWREADY && k < 50) begin @(posedge ACLK); #1; k++; end
    check_eq("awready", {31'd0, AWREADY}, 32'd1);
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic last);
    int k = 0;
    WDATA = d; WSTRB = s; WLAST = last; WVALID = 1'b1;
    #1;
    while (!WREADY && k < 50) begin @(posedge ACLK); #1; k++; end
    check_eq("wready", {31'd0, WREADY}, 32'd1);
    @(posedge ACLK); #1;
    WVALID = 1'b0; WLAST = 1'b0;
  endtask

  task automatic b_resp(input logic [3:0] exp_id, input logic [1:0] exp_resp);
    int k = 0;
    while (!BVALID && k < 50) begin @(posedge ACLK); #1; k++; end
    check_eq("bvalid", {31'd0, BVALID}, 32'd1);
    check_eq("bid", {28'd0, BID}, {28'd0, exp_id});
    check_eq("bresp", {30'd0, BRESP}, {30'd0, exp_resp});
    BREADY = 1'b1;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
  endtask

  task automatic rd_beat(input logic [31:0] exp_d, input logic exp_last,
                         input logic [3:0] exp_id, input int stall);
    int k = 0;
    while (!RVALID && k < 50) begin @(posedge ACLK); #1; k++; end
    check_eq("rvalid", {31'd0, RVALID}, 32'd1);
    for (int s = 0; s < stall; s++) begin
      @(posedge ACLK); #1;
      check_eq("rvalid_stall", {31'd0, RVALID}, 32'd1);
      check_eq("rdata_stall", RDATA, exp_d);
    end
    check_eq("rdata", RDATA, exp_d);
    check_eq("rlast", {31'd0, RLAST}, {31'd0, exp_last});
    check_eq("rresp", {30'd0, RRESP}, 32'd0);
    check_eq("rid", {28'd0, RID}, {28'd0, exp_id});
    RREADY = 1'b1;
    @(posedge ACLK); #1;
    RREADY = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int n;
    // reset state
    repeat (2) @(posedge ACLK);
    #1;
    check_eq("rst_awready", {31'd0, AWREADY}, 32'd0);
    check_eq("rst_arready", {31'd0, ARREADY}, 32'd0);
    check_eq("rst_wready", {31'd0, WREADY}, 32'd0);
    check_eq("rst_bvalid", {31'd0, BVALID}, 32'd0);
    check_eq("rst_rvalid", {31'd0, RVALID}, 32'd0);
    check_eq("rst_rlast", {31'd0, RLAST}, 32'd0);
    check_eq("rst_rdata", RDATA, 32'd0);
    check_eq("rst_bresp", {30'd0, BRESP}, 32'd0);
    check_eq("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check_eq("rst_mem_addr", {10'd0, mem_addr}, 32'd0);
    check_eq("rst_state", {28'd0, dbg_state}, 32'd0);
    ARESETn = 1'b0;

    for (int i = 0; i < 1024; i++) preload(i[9:0], 16'h0000);
    for (int i = 0; i < 8; i++) preload(i[9:0], 16'h1000 + i[15:0]);
    preload(10'h100, 16'h1234);
    preload(10'h101, 16'hABCD);

    // single-beat read with latency check
    ar_hs(4'd5, 32'h200, 8'd0);
    n = 0;
    while (!RVALID && n < 20) begin @(posedge ACLK); #1; n++; end
    check_eq("rd_latency", n, 32'd3);
    rd_beat(32'hABCD1234, 1'b1, 4'd5, 0);

    // 4-beat read with stalls on beats 1 and 3
    ar_hs(4'd2, 32'h0, 8'd3);
    rd_beat(32'h10011000, 1'b0, 4'd2, 0);
    rd_beat(32'h10031002, 1'b0, 4'd2, 2);
    rd_beat(32'h10051004, 1'b0, 4'd2, 0);
    rd_beat(32'h10071006, 1'b1, 4'd2, 2);

    // 2-beat full-strobe write
    aw_hs(4'd3, 32'h40, 8'd1);
    w_beat(32'hDEADBEEF, 4'hF, 1'b0);
    w_beat(32'h01020304, 4'hF, 1'b1);
    b_resp(4'd3, PROT ? 2'b10 : 2'b00);
    check_eq("wr_m20", {16'd0, mem[10'h20]}, PROT ? 32'h0 : 32'hBEEF);
    check_eq("wr_m21", {16'd0, mem[10'h21]}, PROT ? 32'h0 : 32'hDEAD);
    check_eq("wr_m22", {16'd0, mem[10'h22]}, PROT ? 32'h0 : 32'h0304);
    check_eq("wr_m23", {16'd0, mem[10'h23]}, PROT ? 32'h0 : 32'h0102);

    // partial strobe: only the low word written
    preload(10'h40, 16'h7777);
    preload(10'h41, 16'h5555);
    aw_hs(4'd2, 32'h80, 8'd0);
    w_beat(32'h11112222, 4'h3, 1'b1);
    b_resp(4'd2, PROT ? 2'b10 : 2'b00);
    check_eq("strb_lo", {16'd0, mem[10'h40]}, PROT ? 32'h7777 : 32'h2222);
    check_eq("strb_hi", {16'd0, mem[10'h41]}, 32'h5555);

    // missing WLAST on the final beat -> SLVERR
    aw_hs(4'd6, 32'h84, 8'd0);
    w_beat(32'h33334444, 4'hF, 1'b0);
    b_resp(4'd6, 2'b10);

    // simultaneous AW and AR: write first, read after BREADY
    AWID = 4'd9; AWADDR = 32'h100; AWLEN = 8'd0; AWVALID = 1'b1;
    ARID = 4'd4; ARADDR = 32'h100; ARLEN = 8'd0; ARVALID = 1'b1;
    #1;
    check_eq("tie_awready", {31'd0, AWREADY}, 32'd1);
    check_eq("tie_arready", {31'd0, ARREADY}, 32'd0);
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    check_eq("tie_arready_wr", {31'd0, ARREADY}, 32'd0);
    w_beat(32'hCAFEF00D, 4'hF, 1'b1);
    check_eq("tie_arready_b", {31'd0, ARREADY}, 32'd0);
    b_resp(4'd9, PROT ? 2'b10 : 2'b00);
    n = 0;
    while (!ARREADY && n < 50) begin @(posedge ACLK); #1; n++; end
    check_eq("tie_arready_late", {31'd0, ARREADY}, 32'd1);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    rd_beat(PROT ? 32'h0 : 32'hCAFEF00D, 1'b1, 4'd4, 0);

    // reset pulse mid-read-burst
    ar_hs(4'd7, 32'h0, 8'd3);
    n = 0;
    while (!RVALID && n < 50) begin @(posedge ACLK); #1; n++; end
    check_eq("mid_rvalid_pre", {31'd0, RVALID}, 32'd1);
    ARESETn = 1'b1;
    #1;
    check_eq("mid_rvalid_rst", {31'd0, RVALID}, 32'd0);
    check_eq("mid_state_rst", {28'd0, dbg_state}, 32'd0);
    @(posedge ACLK); #1;
    ARESETn = 1'b0;
    ar_hs(4'd5, 32'h200, 8'd0);
    rd_beat(32'hABCD1234, 1'b1, 4'd5, 0);

    repeat (3) @(posedge ACLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_sram_slave_if.md
Name: axi_sram_slave_if

Overview:
- AXI3 slave bridge that maps 32-bit AXI read/write bursts onto a single-port synchronous SRAM with 16-bit words.
- Sits between the accelerator's AXI master and the external memory model.
- Each AXI beat is split into two SRAM accesses, low half first.
- Only one transaction (read or write) is in flight at a time.

Parameters:
- MEM_ADDRW, 22: SRAM word-address width.
- MEM_DW, 16: SRAM data width. Must equal D/2.
- A, 32: AXI address width.
- I, 4: AXI ID width.
- L, 8: AXI burst-length width.
- D, 32: AXI data width.
- M, 4: strobe width, equal to D/8.

Ports:
- ACLK  input  1  clock.
- ARESETn  input  1  reset. Asynchronous, active-high: asserted when 1, despite the codebase name.
- AWID/ARID  input  I  transaction IDs.
- AWADDR/ARADDR  input  A  byte addresses.
- AWLEN/ARLEN  input  L  beats minus 1.
- AWSIZE/ARSIZE [3], AWBURST/ARBURST [2], AWLOCK/ARLOCK [2], AWCACHE/ARCACHE [4], AWPROT/ARPROT [3]  input  accepted and ignored. All transfers are 32-bit INCR.
- AWVALID/ARVALID  input  1; AWREADY/ARREADY  output  1  address handshakes.
- WID  input  I, ignored. WDATA  input  D. WSTRB  input  M. WLAST  input  1. WVALID  input  1. WREADY  output  1.
- BID  output  I. BRESP  output  2. BVALID  output  1. BREADY  input  1.
- RID  output  I. RDATA  output  D. RRESP  output  2. RLAST  output  1. RVALID  output  1. RREADY  input  1.
- mem_addr  output  MEM_ADDRW  SRAM word address.
- mem_we  output  1  SRAM write enable.
- mem_di  output  MEM_DW  SRAM write data.
- mem_do  input  MEM_DW  SRAM read data, registered, valid one cycle after the address.

Behaviour:
- Reset: state=IDLE. All READY/VALID outputs 0, RLAST=0, RDATA=0, BRESP=0, mem_we=0, mem_addr=0. Reset mid-burst aborts the burst without a response.
- Word address: start = ADDR[MEM_ADDRW:1]. Advances by 2 per beat and truncates (wraps) at MEM_ADDRW bits.
- IDLE: AWREADY=AWVALID; ARREADY=ARVALID&~AWVALID, so writes win a tie. The handshake latches ID, word address and LEN, and clears the beat counter.
- Read states RD_LO → RD_HI → RD_CAP → RD_OUT:
  - RD_LO: mem_addr=a.
  - RD_HI: mem_addr=a+1; capture mem_do into RDATA[15:0].
  - RD_CAP: capture mem_do into RDATA[31:16].
  - RD_OUT: RVALID=1, RID=latched ID, RRESP=00, RLAST=(beat==LEN).
  - Latency: RVALID is first high 3 clock edges after the AR handshake edge.
  - RDATA/RLAST stay stable while RVALID&~RREADY.
  - On RREADY: last beat → IDLE; otherwise beat+1, a+2, → RD_LO.
- Write states WR_WAIT → WR_LO → WR_HI:
  - WR_WAIT: WREADY=1. The handshake latches WDATA, WSTRB and WLAST.
  - WR_LO: mem_addr=a, mem_di=data[15:0], mem_we=|strb[1:0].
  - WR_HI: mem_addr=a+1, mem_di=data[31:16], mem_we=|strb[3:2].
  - Any set strobe bit writes the full 16-bit half. All-zero strobes write nothing.
  - After WR_HI: beat==LEN → WR_RESP; otherwise beat+1, a+2, → WR_WAIT.
  - mem_we is 0 in every other state.
- WR_RESP: BVALID=1, BID=latched AWID. BRESP=00, or 10 (SLVERR) if any latched WLAST disagreed with (beat==LEN). Burst length is always taken from AWLEN. On BREADY → IDLE.
- Invariants:
  - No READY is asserted outside its state.
  - Back-to-back transactions need at least one IDLE cycle between them.

Optional Feature:
- AXI_SRAM_WR_PROTECT_EN defined: write bursts are fully accepted with the same handshakes and timing. mem_we is held 0 and BRESP is always 10 (SLVERR). Reads are unchanged.
- Undefined: writes behave as above.

Test Plan:
- Preload mem[0x100]=0x1234, mem[0x101]=0xABCD. AR addr 0x200, len 0 → one beat, RDATA=0xABCD1234, RLAST=1, RRESP=00, RID echoes ARID=5. RVALID rises 3 edges after the handshake.
- 4-beat read at byte 0x0, RREADY toggled 1,0,1,0 → beats return mem[1:0], mem[3:2], mem[5:4], mem[7:6] in order. RLAST only on beat 3. Data is held during stalls.
- AW addr 0x40 len 1 with WDATA 0xDEADBEEF then 0x01020304, WSTRB=F, WLAST on beat 1 → words 0x20..0x23 = BEEF, DEAD, 0304, 0102. BRESP=00, BID=AWID.
- WSTRB=0x3 on a single beat → only the low word is written; the high word is unchanged. WLAST=0 on the final beat → BRESP=10.
- AWVALID and ARVALID asserted in the same cycle → AWREADY first. The read completes after BREADY.
- ARESETn pulsed mid-read-burst → RVALID drops immediately and the next AR is accepted from IDLE. With AXI_SRAM_WR_PROTECT_EN, a write leaves memory unchanged and BRESP=10.
